matrix_operand_loader: RTL and testbench
========================================

// Module: matrix_operand_loader
// PURPOSE
//  Front-end control stage directly upstream of the matrix ALU. Accepts a command (opcode + scalar) and a byte
//  stream of operand elements, assembles matrizA/matrizB (5x5, 8-bit, packed), runs the ALU start/done handshake,
//  captures matriz_resultante and streams the result back out byte-serially. Sole owner of the ALU start line.
// PARAMETERS
//  N            5     matrix dimension; packed bus width = N*N*W
//  W            8     element width in bits
//  TIMEOUT_CYC  1024  max cycles in EXEC waiting for alu_done before abort
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  rst_n        in   1        synchronous, active-low reset
//  cmd_valid    in   1        command offered
//  cmd_ready    out  1        high only in IDLE
//  cmd_opcode   in   4        ALU opcode
//  cmd_scalar   in   8        scalar for opcode 1000
//  in_valid     in   1        operand element offered
//  in_ready     out  1        high only in LOAD_A/LOAD_B
//  in_data      in   W        element, row-major; element k -> bits [k*W +: W]
//  out_valid    out  1        result element offered
//  out_ready    in   1        consumer accepts element
//  out_data     out  W        result element, row-major
//  out_last     out  1        high with final result element
//  alu_opcode   out  4        to ALU opcode (registered at cmd accept)
//  alu_scalar   out  8        to ALU data_escalar
//  alu_matrizA  out  N*N*W    to ALU matrizA
//  alu_matrizB  out  N*N*W    to ALU matrizB (zero for unary ops)
//  alu_start    out  1        to ALU start, level
//  alu_result   in   N*N*W    from ALU matriz_resultante
//  alu_done     in   1        from ALU done
//  busy         out  1        state != IDLE
//  err_opcode   out  1        sticky, cleared on next cmd accept
//  err_timeout  out  1        sticky, cleared on next cmd accept
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; alu_start, out_valid, out_last, busy, err_* = 0; operand/result regs,
//    counters = 0; cmd_ready=1. Reset mid-operation aborts with no output; ALU done clears 1 cycle after start drops.
//  - Transfers occur when valid&ready at posedge. Element counter 0..N*N-1, no wrap beyond; last index -> next state.
//  - Opcode classes: binary {0011 soma,0100 sub,0101 mult}; unary {0110 transp,0111 oposta,1000 escalar};
//    det {1011}; all others illegal -> set err_opcode, stay IDLE, ALU untouched.
//  - FSM: IDLE -cmd accept-> LOAD_A (zero matrizB) -25 elems-> LOAD_B (binary) or EXEC (unary/det);
//    LOAD_B -25 elems-> EXEC; EXEC: alu_start=1, timeout counter runs; on alu_done=1 capture alu_result,
//    alu_start=0 next cycle -> WAIT_CLR; WAIT_CLR: wait alu_done=0 (start must never reassert while done=1)
//    -> DRAIN; DRAIN: stream elements, out_valid held until out_ready; -> IDLE after last.
//  - Operands stable for whole EXEC (ALU mult/det are multicycle); never written outside LOAD_*.
//  - Det opcode: result is 8 bits in [W-1:0]; DRAIN emits exactly 1 element with out_last=1. Others emit N*N.
//  - Timeout: counter reaches TIMEOUT_CYC in EXEC without done -> alu_start=0, err_timeout=1, go WAIT_CLR,
//    then IDLE without DRAIN.
//  - out_data/out_valid registered; back-to-back elements at 1/cycle when out_ready=1. out_valid never drops
//    while out_ready=0. Latency cmd->first out for soma with no stalls: 1+25+25+EXEC+WAIT_CLR+1 cycles.
//  - cmd_valid outside IDLE ignored (cmd_ready=0); in_valid outside LOAD_* ignored.
// STRUCTURE
//  - Shared package mat_pkg: opcode localparams (OP_SOMA..OP_DET4), N, W, MAT_BITS=N*N*W, state enum.
//  - One sub-module natural: mat_byte_serializer (result reg + index counter + valid/ready/last) used in DRAIN.
//  - FSM, packing and timeout in this module; no combinational path from in_* to out_*.
// TESTING
//  - Soma: A=all 1, B=all 2, ready always 1 -> 25 out bytes of 3, out_last on 25th, alu_start high only in EXEC.
//  - Oposta unary: load 25 bytes A, no B requested (in_ready low after 25th) -> alu_matrizB==0, 25 results out.
//  - Det 1011 with ALU model done after 8 cycles -> single out byte = model det, out_last=1, back to IDLE.
//  - Opcode 0001 -> err_opcode=1, cmd_ready stays 1, alu_start never rises; next legal cmd clears err_opcode.
//  - ALU model never sets done, TIMEOUT_CYC=16 -> alu_start drops after 16 EXEC cycles, err_timeout=1, no output.
//  - rst_n low during LOAD_B and during DRAIN with out_ready toggling -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix operand loader: geometry, opcodes, FSM states
// and the opcode classifier.
package mat_pkg;

    localparam int unsigned N        = 5;
    localparam int unsigned W        = 8;
    localparam int unsigned NN       = N * N;
    localparam int unsigned MAT_BITS = NN * W;
    localparam int unsigned IDX_W    = $clog2(NN);

    localparam logic [3:0] OP_SOMA    = 4'b0011;
    localparam logic [3:0] OP_SUB     = 4'b0100;
    localparam logic [3:0] OP_MULT    = 4'b0101;
    localparam logic [3:0] OP_TRANSP  = 4'b0110;
    localparam logic [3:0] OP_OPOSTA  = 4'b0111;
    localparam logic [3:0] OP_ESCALAR = 4'b1000;
    localparam logic [3:0] OP_DET4    = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_WAIT_CLR,
        ST_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        CLS_ILLEGAL,
        CLS_BINARY,
        CLS_UNARY,
        CLS_DET
    } op_class_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] scalar;
    } cmd_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        case (op)
            OP_SOMA, OP_SUB, OP_MULT:            return CLS_BINARY;
            OP_TRANSP, OP_OPOSTA, OP_ESCALAR:    return CLS_UNARY;
            OP_DET4:                             return CLS_DET;
            default:                             return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Command/operand/result streams plus the ALU-facing bus of the operand loader.
// master = environment (command source, element source/sink, ALU); slave = loader.
interface matrix_operand_loader_if;
    import mat_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_opcode;
    logic [7:0]          cmd_scalar;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_data;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic                out_last;
    logic [3:0]          alu_opcode;
    logic [7:0]          alu_scalar;
    logic [MAT_BITS-1:0] alu_matrizA;
    logic [MAT_BITS-1:0] alu_matrizB;
    logic                alu_start;
    logic [MAT_BITS-1:0] alu_result;
    logic                alu_done;
    logic                busy;
    logic                err_opcode;
    logic                err_timeout;

    modport master (
        output cmd_valid, cmd_opcode, cmd_scalar, in_valid, in_data, out_ready,
               alu_result, alu_done,
        input  cmd_ready, in_ready, out_valid, out_data, out_last, alu_opcode,
               alu_scalar, alu_matrizA, alu_matrizB, alu_start, busy,
               err_opcode, err_timeout
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_scalar, in_valid, in_data, out_ready,
               alu_result, alu_done,
        output cmd_ready, in_ready, out_valid, out_data, out_last, alu_opcode,
               alu_scalar, alu_matrizA, alu_matrizB, alu_start, busy,
               err_opcode, err_timeout
    );

endinterface

// File: rtl/mat_byte_serializer.sv
// Holds the captured ALU result and streams it out one element per accepted beat.
module mat_byte_serializer
    import mat_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                capture,
    input  logic [MAT_BITS-1:0] result,
    input  logic                start,
    input  logic                single,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [W-1:0]        out_data,
    output logic                out_last
);

    logic [MAT_BITS-1:0] res_q;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    last_idx;
    logic [IDX_W-1:0]    idx_nxt_c;

    assign idx_nxt_c = idx + IDX_W'(1);

    // Capture and start never coincide: capture happens in EXEC, start on leaving WAIT_CLR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q     <= '0;
            idx       <= '0;
            last_idx  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (capture) begin
                res_q <= result;
            end
            if (start) begin
                out_valid <= 1'b1;
                idx       <= '0;
                out_data  <= res_q[W-1:0];
                last_idx  <= single ? '0 : IDX_W'(NN - 1);
                out_last  <= single;
            end else if (out_valid && out_ready) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    idx      <= idx_nxt_c;
                    out_data <= res_q[32'(idx_nxt_c) * W +: W];
                    out_last <= (idx_nxt_c == last_idx);
                end
            end
        end
    end

endmodule

// File: rtl/matrix_operand_loader.sv
// Control stage in front of the matrix ALU: command intake, operand assembly,
// start/done handshake with timeout, and byte-serial result drain.
module matrix_operand_loader
    import mat_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_operand_loader_if.slave  bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;

    state_t              state;
    state_t              state_n;
    op_class_t           cls_q;
    cmd_t                cmd_q;
    logic [IDX_W-1:0]    elem_idx;
    logic [TO_W-1:0]     to_cnt;
    logic [MAT_BITS-1:0] mat_a;
    logic [MAT_BITS-1:0] mat_b;
    logic                timed_out;
    logic                err_opcode_q;
    logic                err_timeout_q;
    logic                cmd_ready_q;
    logic                in_ready_q;
    logic                busy_q;
    logic                alu_start_q;

    logic                cmd_fire_c;
    logic                cmd_legal_c;
    logic                in_fire_c;
    logic                elem_last_c;
    logic                capture_c;
    logic                timeout_c;
    logic                ser_start_c;
    logic                ser_done_c;

    logic                ser_valid;
    logic [W-1:0]        ser_data;
    logic                ser_last;

    assign cmd_fire_c  = bus.cmd_valid && cmd_ready_q;
    assign cmd_legal_c = (op_class(bus.cmd_opcode) != CLS_ILLEGAL);
    assign in_fire_c   = bus.in_valid && in_ready_q;
    assign elem_last_c = (elem_idx == IDX_W'(NN - 1));
    assign ser_done_c  = ser_valid && bus.out_ready && ser_last;

    // Next-state and single-cycle control strobes.
    always_comb begin
        state_n     = state;
        capture_c   = 1'b0;
        timeout_c   = 1'b0;
        ser_start_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire_c && cmd_legal_c) state_n = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                if (in_fire_c && elem_last_c)
                    state_n = (cls_q == CLS_BINARY) ? ST_LOAD_B : ST_EXEC;
            end
            ST_LOAD_B: begin
                if (in_fire_c && elem_last_c) state_n = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.alu_done) begin
                    capture_c = 1'b1;
                    state_n   = ST_WAIT_CLR;
                end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    timeout_c = 1'b1;
                    state_n   = ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: begin
                // Start may only return once the ALU has dropped done.
                if (!bus.alu_done) begin
                    if (timed_out) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n     = ST_DRAIN;
                        ser_start_c = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (ser_done_c) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register; handshake/status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            alu_start_q <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_ready_q <= (state_n == ST_IDLE);
            in_ready_q  <= (state_n == ST_LOAD_A) || (state_n == ST_LOAD_B);
            busy_q      <= (state_n != ST_IDLE);
            alu_start_q <= (state_n == ST_EXEC);
        end
    end

    // Command, operand and timeout datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cls_q         <= CLS_ILLEGAL;
            cmd_q         <= '0;
            elem_idx      <= '0;
            to_cnt        <= '0;
            mat_a         <= '0;
            mat_b         <= '0;
            timed_out     <= 1'b0;
            err_opcode_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (cmd_fire_c) begin
                err_timeout_q <= 1'b0;
                err_opcode_q  <= !cmd_legal_c;
                if (cmd_legal_c) begin
                    cmd_q     <= '{opcode: bus.cmd_opcode, scalar: bus.cmd_scalar};
                    cls_q     <= op_class(bus.cmd_opcode);
                    mat_b     <= '0;
                    elem_idx  <= '0;
                    timed_out <= 1'b0;
                end
            end
            if (in_fire_c) begin
                if (state == ST_LOAD_A) mat_a[32'(elem_idx) * W +: W] <= bus.in_data;
                else                    mat_b[32'(elem_idx) * W +: W] <= bus.in_data;
                elem_idx <= elem_last_c ? '0 : elem_idx + IDX_W'(1);
            end
            if (state == ST_EXEC && !bus.alu_done) to_cnt <= to_cnt + TO_W'(1);
            else                                    to_cnt <= '0;
            if (timeout_c) begin
                err_timeout_q <= 1'b1;
                timed_out     <= 1'b1;
            end
        end
    end

    mat_byte_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture_c),
        .result    (bus.alu_result),
        .start     (ser_start_c),
        .single    (cls_q == CLS_DET),
        .out_ready (bus.out_ready),
        .out_valid (ser_valid),
        .out_data  (ser_data),
        .out_last  (ser_last)
    );

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;
    assign bus.alu_start   = alu_start_q;
    assign bus.alu_opcode  = cmd_q.opcode;
    assign bus.alu_scalar  = cmd_q.scalar;
    assign bus.alu_matrizA = mat_a;
    assign bus.alu_matrizB = mat_b;
    assign bus.err_opcode  = err_opcode_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.out_valid   = ser_valid;
    assign bus.out_data    = ser_data;
    assign bus.out_last    = ser_last;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader with a behavioural ALU model.
module tb_matrix_operand_loader;
    import mat_pkg::*;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic clk;
    logic rst_n;
    matrix_operand_loader_if bus();

    matrix_operand_loader #(.TIMEOUT_CYC(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   out_count = 0;
    int   start_cycles = 0;
    int   start_rises = 0;
    int   start_excl_viol = 0;
    int   alu_lat = 3;
    bit   never_done = 1'b0;
    bit   bp_en = 1'b0;
    int   alu_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU: done after alu_lat cycles of start, cleared the cycle after start drops.
    function automatic logic [MAT_BITS-1:0] alu_compute();
        logic [MAT_BITS-1:0] r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        r = '0;
        for (int k = 0; k < int'(NN); k++) begin
            a = bus.alu_matrizA[k*W +: W];
            b = bus.alu_matrizB[k*W +: W];
            case (bus.alu_opcode)
                OP_SOMA:   r[k*W +: W] = a + b;
                OP_SUB:    r[k*W +: W] = a - b;
                OP_OPOSTA: r[k*W +: W] = 8'd0 - a;
                default:   r[k*W +: W] = a;
            endcase
        end
        if (bus.alu_opcode == OP_DET4) begin
            r = '1;
            r[W-1:0] = 8'h5A;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.alu_start !== 1'b1) begin
            bus.alu_done <= 1'b0;
            alu_cnt      <= 0;
        end else if (!bus.alu_done && !never_done) begin
            if (alu_cnt == alu_lat - 1) begin
                bus.alu_done   <= 1'b1;
                bus.alu_result <= alu_compute();
            end else begin
                alu_cnt <= alu_cnt + 1;
            end
        end
    end

    // Consumer: steady ready, or toggling every cycle for backpressure.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_en ? ~bus.out_ready : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted output and watches the ALU handshake.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_start = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (prev_stall)
                check("out_hold", 64'({bus.out_valid, bus.out_data}), 64'({1'b1, prev_data}));
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(bus.out_data), 64'(0));
                    check("unexpected_out_valid", 64'(bus.out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(bus.out_data), 64'(e.data));
                    check("out_last", 64'(bus.out_last), 64'(e.last));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.alu_start) start_cycles++;
            if (bus.alu_start && !prev_start) begin
                start_rises++;
                check("start_while_done", 64'(bus.alu_done), 64'(0));
            end
            if (bus.alu_start && (bus.in_ready || bus.out_valid || bus.cmd_ready)) start_excl_viol++;
            prev_start = bus.alu_start;
        end
    end

    task automatic send_cmd(input logic [3:0] op, input logic [7:0] sc);
        logic acc;
        acc = 1'b0;
        bus.cmd_opcode = op;
        bus.cmd_scalar = sc;
        bus.cmd_valid  = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        check("cmd_accept", 64'(acc), 64'(1));
    endtask

    task automatic send_elem(input logic [W-1:0] d);
        logic acc;
        acc = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("elem_accept", 64'(acc), 64'(1));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!bus.busy && exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check(name, 64'(i < budget), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'(0));
        check({tag, "_busy"},      64'(bus.busy),      64'(0));
        check({tag, "_alu_start"}, 64'(bus.alu_start), 64'(0));
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_out_last"},  64'(bus.out_last),  64'(0));
        check({tag, "_errs"},      64'({bus.err_opcode, bus.err_timeout}), 64'(0));
        check({tag, "_matA_zero"}, 64'(bus.alu_matrizA == '0), 64'(1));
    endtask

    initial begin
        int base_out;
        int base_start;
        int base_rise;
        int i;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_scalar = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Soma: A=1, B=2 -> 25 elements of 3
        alu_lat = 3;
        base_out = out_count;
        base_start = start_cycles;
        for (int k = 0; k < int'(NN); k++) exp_q.push_back('{data: 8'd3, last: (k == int'(NN) - 1)});
        send_cmd(OP_SOMA, 8'd0);
        check("soma_busy", 64'({bus.busy, bus.cmd_ready, bus.in_ready}), 64'(3'b101));
        for (int k = 0; k < int'(NN); k++) send_elem(8'd1);
        check("soma_loadb_in_ready", 64'(bus.in_ready), 64'(1));
        for (int k = 0; k < int'(NN); k++) send_elem(8'd2);
        wait_idle("soma_done", 300);
        check("soma_count", 64'(out_count - base_out), 64'(25));
        check("soma_start_cycles", 64'(start_cycles - base_start), 64'(4));

        // Oposta: unary, B must be zeroed and never requested
        base_out = out_count;
        for (int k = 0; k < int'(NN); k++) exp_q.push_back('{data: 8'(8'd0 - 8'(k + 1)), last: (k == int'(NN) - 1)});
        send_cmd(OP_OPOSTA, 8'd0);
        for (int k = 0; k < int'(NN); k++) send_elem(8'(k + 1));
        check("oposta_in_ready_low", 64'(bus.in_ready), 64'(0));
        check("oposta_matB_zero", 64'(bus.alu_matrizB == '0), 64'(1));
        check("oposta_matA_e7", 64'(bus.alu_matrizA[7*W +: W]), 64'(8));
        check("oposta_opcode", 64'(bus.alu_opcode), 64'(OP_OPOSTA));
        wait_idle("oposta_done", 300);
        check("oposta_count", 64'(out_count - base_out), 64'(25));

        // Det: one element, done after 8 cycles
        alu_lat = 8;
        base_out = out_count;
        exp_q.push_back('{data: 8'h5A, last: 1'b1});
        send_cmd(OP_DET4, 8'd0);
        for (int k = 0; k < int'(NN); k++) send_elem(8'(3 * k));
        wait_idle("det_done", 300);
        check("det_count", 64'(out_count - base_out), 64'(1));
        check("det_idle", 64'({bus.cmd_ready, bus.busy}), 64'(2'b10));

        // Illegal opcode, then a legal command under backpressure clears the flag
        alu_lat = 3;
        base_rise = start_rises;
        send_cmd(4'b0001, 8'd0);
        check("illegal_err", 64'(bus.err_opcode), 64'(1));
        check("illegal_idle", 64'({bus.cmd_ready, bus.busy}), 64'(2'b10));
        repeat (5) @(posedge clk);
        #1;
        check("illegal_no_start", 64'(start_rises - base_rise), 64'(0));
        base_out = out_count;
        for (int k = 0; k < int'(NN); k++) exp_q.push_back('{data: 8'd12, last: (k == int'(NN) - 1)});
        send_cmd(OP_SOMA, 8'd0);
        check("illegal_err_cleared", 64'(bus.err_opcode), 64'(0));
        bp_en = 1'b1;
        for (int k = 0; k < int'(NN); k++) send_elem(8'd5);
        for (int k = 0; k < int'(NN); k++) send_elem(8'd7);
        wait_idle("bp_done", 400);
        bp_en = 1'b0;
        check("bp_count", 64'(out_count - base_out), 64'(25));

        // Timeout: ALU never answers
        never_done = 1'b1;
        base_out = out_count;
        base_start = start_cycles;
        send_cmd(OP_TRANSP, 8'd0);
        for (int k = 0; k < int'(NN); k++) send_elem(8'(k));
        wait_idle("timeout_idle", 200);
        check("timeout_err", 64'(bus.err_timeout), 64'(1));
        check("timeout_start_cycles", 64'(start_cycles - base_start), 64'(16));
        check("timeout_no_out", 64'(out_count - base_out), 64'(0));
        never_done = 1'b0;

        // Reset during LOAD_B
        send_cmd(OP_SUB, 8'd0);
        check("next_cmd_clears_timeout", 64'(bus.err_timeout), 64'(0));
        for (int k = 0; k < int'(NN) + 3; k++) send_elem(8'd9);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_loadb");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset during DRAIN with out_ready toggling
        base_out = out_count;
        for (int k = 0; k < int'(NN); k++) exp_q.push_back('{data: 8'd3, last: (k == int'(NN) - 1)});
        send_cmd(OP_SOMA, 8'd0);
        for (int k = 0; k < int'(NN); k++) send_elem(8'd1);
        for (int k = 0; k < int'(NN); k++) send_elem(8'd2);
        bp_en = 1'b1;
        for (i = 0; i < 200; i++) begin
            if (out_count - base_out >= 5) break;
            @(posedge clk);
            #1;
        end
        check("drain_progress", 64'(i < 200), 64'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_drain");
        exp_q.delete();
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_no_out", 64'(bus.out_valid), 64'(0));
        check("start_exclusive", 64'(start_excl_viol), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
